// File: rtl/id_ex_stage_if.sv
// Bundle between the decoder/ID stage and the ID/EX pipeline register.
// The master drives ID-side fields and pipeline controls; the slave returns the EX-side state.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic [1:0]        id_alu_op;
    logic              id_alu_src;
    logic              id_reg_dst;
    logic              id_branch;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_reg_write;
    logic              id_mem_to_reg;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;

    logic [1:0]        ex_alu_op;
    logic              ex_alu_src;
    logic              ex_reg_dst;
    logic              ex_branch;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic              ex_valid;
    logic              hazard_detected;
    logic              pc_write;
    logic              if_id_write;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output stall, flush, id_alu_op, id_alu_src, id_reg_dst, id_branch, id_mem_read,
               id_mem_write, id_reg_write, id_mem_to_reg, id_rs, id_rt, id_rd, id_rdata1,
               id_rdata2, id_imm, id_pc4,
        input  ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_mem_to_reg, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
               ex_pc4, ex_valid, hazard_detected, pc_write, if_id_write, stall_cnt
    );

    modport slave (
        input  stall, flush, id_alu_op, id_alu_src, id_reg_dst, id_branch, id_mem_read,
               id_mem_write, id_reg_write, id_mem_to_reg, id_rs, id_rt, id_rd, id_rdata1,
               id_rdata2, id_imm, id_pc4,
        output ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_mem_to_reg, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
               ex_pc4, ex_valid, hazard_detected, pc_write, if_id_write, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// Flush beats stall beats hazard bubble beats normal capture.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    logic [1:0]        alu_op_q;
    logic              alu_src_q;
    logic              reg_dst_q;
    logic              branch_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic [REG_W-1:0]  rs_q;
    logic [REG_W-1:0]  rt_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] pc4_q;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              hazard;

    always_comb begin
        hazard = valid_q & mem_read_q & (rt_q != '0) &
                 ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));
    end

    assign bus.hazard_detected = hazard;
    assign bus.pc_write        = ~(hazard | bus.stall);
    assign bus.if_id_write     = ~(hazard | bus.stall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            branch_q     <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            imm_q        <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
        end else if (!bus.stall || bus.flush) begin
            // Data fields always follow ID here; on a bubble they are don't-care.
            rs_q     <= bus.id_rs;
            rt_q     <= bus.id_rt;
            rd_q     <= bus.id_rd;
            rdata1_q <= bus.id_rdata1;
            rdata2_q <= bus.id_rdata2;
            imm_q    <= bus.id_imm;
            pc4_q    <= bus.id_pc4;
            if (bus.flush || hazard) begin
                alu_op_q     <= '0;
                alu_src_q    <= 1'b0;
                reg_dst_q    <= 1'b0;
                branch_q     <= 1'b0;
                mem_read_q   <= 1'b0;
                mem_write_q  <= 1'b0;
                reg_write_q  <= 1'b0;
                mem_to_reg_q <= 1'b0;
                valid_q      <= 1'b0;
            end else begin
                alu_op_q     <= bus.id_alu_op;
                alu_src_q    <= bus.id_alu_src;
                reg_dst_q    <= bus.id_reg_dst;
                branch_q     <= bus.id_branch;
                mem_read_q   <= bus.id_mem_read;
                mem_write_q  <= bus.id_mem_write;
                reg_write_q  <= bus.id_reg_write;
                mem_to_reg_q <= bus.id_mem_to_reg;
                valid_q      <= 1'b1;
            end
            if (!bus.flush && hazard && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.ex_alu_op     = alu_op_q;
    assign bus.ex_alu_src    = alu_src_q;
    assign bus.ex_reg_dst    = reg_dst_q;
    assign bus.ex_branch     = branch_q;
    assign bus.ex_mem_read   = mem_read_q;
    assign bus.ex_mem_write  = mem_write_q;
    assign bus.ex_reg_write  = reg_write_q;
    assign bus.ex_mem_to_reg = mem_to_reg_q;
    assign bus.ex_rs         = rs_q;
    assign bus.ex_rt         = rt_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_rdata1     = rdata1_q;
    assign bus.ex_rdata2     = rdata2_q;
    assign bus.ex_imm        = imm_q;
    assign bus.ex_pc4        = pc4_q;
    assign bus.ex_valid      = valid_q;
    assign bus.stall_cnt     = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against an instruction-level model.
module tb_id_ex_stage;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [1:0]        alu_op;
        logic              alu_src;
        logic              reg_dst;
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
    } instr_t;

    logic clk;
    logic reset;

    id_ex_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: the instruction sitting in EX, whether it is real, and the stall count.
    instr_t m_ex;
    bit     m_valid;
    int     m_cnt;

    instr_t in_i;
    bit     in_stall;
    bit     in_flush;
    bit     exp_haz;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ctrl_of(input instr_t f);
        return {f.alu_op, f.alu_src, f.reg_dst, f.branch, f.mem_read, f.mem_write,
                f.reg_write, f.mem_to_reg};
    endfunction

    function automatic logic [142:0] data_of(input instr_t f);
        return {f.rs, f.rt, f.rd, f.rdata1, f.rdata2, f.imm, f.pc4};
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {bus.ex_alu_op, bus.ex_alu_src, bus.ex_reg_dst, bus.ex_branch, bus.ex_mem_read,
                bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_to_reg};
    endfunction

    function automatic logic [142:0] dut_data();
        return {bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm,
                bus.ex_pc4};
    endfunction

    function automatic instr_t rand_instr();
        instr_t f;
        f.alu_op     = 2'($urandom_range(0, 3));
        f.alu_src    = 1'($urandom_range(0, 1));
        f.reg_dst    = 1'($urandom_range(0, 1));
        f.branch     = 1'($urandom_range(0, 1));
        f.mem_read   = 1'($urandom_range(0, 1));
        f.mem_write  = 1'($urandom_range(0, 1));
        f.reg_write  = 1'($urandom_range(0, 1));
        f.mem_to_reg = 1'($urandom_range(0, 1));
        // Small register range so load-use conflicts happen often.
        f.rs         = REG_W'($urandom_range(0, 3));
        f.rt         = REG_W'($urandom_range(0, 3));
        f.rd         = REG_W'($urandom_range(0, 31));
        f.rdata1     = $urandom;
        f.rdata2     = $urandom;
        f.imm        = $urandom;
        f.pc4        = $urandom;
        return f;
    endfunction

    function automatic instr_t make_lw(input int rs, input int rt);
        instr_t f = '0;
        f.mem_read   = 1'b1;
        f.mem_to_reg = 1'b1;
        f.alu_src    = 1'b1;
        f.reg_write  = 1'b1;
        f.rs         = REG_W'(rs);
        f.rt         = REG_W'(rt);
        f.imm        = 32'h0000_0004;
        f.pc4        = 32'h0000_0100;
        return f;
    endfunction

    task automatic drive();
        bus.stall         = in_stall;
        bus.flush         = in_flush;
        bus.id_alu_op     = in_i.alu_op;
        bus.id_alu_src    = in_i.alu_src;
        bus.id_reg_dst    = in_i.reg_dst;
        bus.id_branch     = in_i.branch;
        bus.id_mem_read   = in_i.mem_read;
        bus.id_mem_write  = in_i.mem_write;
        bus.id_reg_write  = in_i.reg_write;
        bus.id_mem_to_reg = in_i.mem_to_reg;
        bus.id_rs         = in_i.rs;
        bus.id_rt         = in_i.rt;
        bus.id_rd         = in_i.rd;
        bus.id_rdata1     = in_i.rdata1;
        bus.id_rdata2     = in_i.rdata2;
        bus.id_imm        = in_i.imm;
        bus.id_pc4        = in_i.pc4;
    endtask

    task automatic model_reset();
        m_ex    = '0;
        m_valid = 0;
        m_cnt   = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".ex_valid"}, 160'(bus.ex_valid), 160'(m_valid));
        chk({tag, ".ex_ctrl"}, 160'(dut_ctrl()), 160'(ctrl_of(m_ex)));
        if (m_valid) chk({tag, ".ex_data"}, 160'(dut_data()), 160'(data_of(m_ex)));
        chk({tag, ".stall_cnt"}, 160'(bus.stall_cnt), 160'(m_cnt));
    endtask

    // One pipeline cycle: drive ID, check hazard outputs, clock, advance model, check EX.
    task automatic step(input string tag);
        instr_t bub;
        drive();
        #2;
        exp_haz = m_valid && m_ex.mem_read && (m_ex.rt != 0) &&
                  ((m_ex.rt == in_i.rs) || (m_ex.rt == in_i.rt));
        chk({tag, ".hazard"}, 160'(bus.hazard_detected), 160'(exp_haz));
        chk({tag, ".pc_write"}, 160'(bus.pc_write), 160'(!(exp_haz || in_stall)));
        chk({tag, ".if_id_write"}, 160'(bus.if_id_write), 160'(!(exp_haz || in_stall)));
        @(posedge clk);
        #1;
        bub            = in_i;
        bub.alu_op     = 2'b00;
        bub.alu_src    = 1'b0;
        bub.reg_dst    = 1'b0;
        bub.branch     = 1'b0;
        bub.mem_read   = 1'b0;
        bub.mem_write  = 1'b0;
        bub.reg_write  = 1'b0;
        bub.mem_to_reg = 1'b0;
        if (in_flush) begin
            m_ex    = bub;
            m_valid = 0;
        end else if (in_stall) begin
            m_valid = m_valid;
        end else if (exp_haz) begin
            m_ex    = bub;
            m_valid = 0;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_ex    = in_i;
            m_valid = 1;
        end
        check_regs(tag);
    endtask

    initial begin
        instr_t held;
        reset    = 1'b1;
        in_i     = '0;
        in_stall = 0;
        in_flush = 0;
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs("por");
        chk("por.data_zero", 160'(dut_data()), 160'(0));
        reset = 1'b0;

        // R-type pass-through
        in_i           = '0;
        in_i.alu_op    = 2'b10;
        in_i.reg_dst   = 1'b1;
        in_i.reg_write = 1'b1;
        in_i.rdata1    = 32'h0000_0010;
        in_i.rd        = 5'd3;
        step("rtype");
        chk("rtype.alu_op", 160'(bus.ex_alu_op), 160'(2'b10));
        chk("rtype.rdata1", 160'(bus.ex_rdata1), 160'(32'h10));
        chk("rtype.valid", 160'(bus.ex_valid), 160'(1'b1));

        // Load-use: lw rt=8 then a consumer of r8
        in_i = make_lw(2, 8);
        step("lu_lw");
        in_i           = '0;
        in_i.alu_op    = 2'b10;
        in_i.reg_write = 1'b1;
        in_i.rs        = 5'd8;
        in_i.rt        = 5'd9;
        in_i.rd        = 5'd10;
        step("lu_bubble");
        chk("lu_bubble.valid", 160'(bus.ex_valid), 160'(1'b0));
        chk("lu_bubble.ctrl", 160'(dut_ctrl()), 160'(0));
        chk("lu_bubble.cnt", 160'(bus.stall_cnt), 160'(1));
        step("lu_dep");
        chk("lu_dep.valid", 160'(bus.ex_valid), 160'(1'b1));
        chk("lu_dep.rs", 160'(bus.ex_rs), 160'(5'd8));

        // Register zero never conflicts
        in_i = make_lw(1, 0);
        step("zero_lw");
        in_i           = '0;
        in_i.reg_write = 1'b1;
        step("zero_dep");
        chk("zero_dep.valid", 160'(bus.ex_valid), 160'(1'b1));
        chk("zero_dep.cnt", 160'(bus.stall_cnt), 160'(1));

        // Stall hold for 3 cycles, then flush with a valid lw in ID
        in_i          = rand_instr();
        in_i.mem_read = 1'b0;
        held          = in_i;
        step("pre_stall");
        in_stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_i = rand_instr();
            step("stall");
            chk("stall.hold_data", 160'(dut_data()), 160'(data_of(held)));
            chk("stall.hold_ctrl", 160'(dut_ctrl()), 160'(ctrl_of(held)));
        end
        in_stall = 0;
        in_flush = 1;
        in_i     = make_lw(3, 4);
        step("flush");
        chk("flush.valid", 160'(bus.ex_valid), 160'(1'b0));
        chk("flush.mem_read", 160'(bus.ex_mem_read), 160'(1'b0));
        in_flush = 0;

        // Four more conflicts bring the count to 5, then a reg-writing instruction
        in_i = make_lw(8, 8);
        for (int i = 0; i < 8; i++) step("to5");
        chk("to5.cnt", 160'(bus.stall_cnt), 160'(5));
        in_i           = '0;
        in_i.reg_write = 1'b1;
        in_i.rs        = 5'd8;
        step("pre_reset");
        chk("pre_reset.reg_write", 160'(bus.ex_reg_write), 160'(1'b1));

        // Mid-cycle asynchronous reset
        reset = 1'b1;
        #2;
        model_reset();
        chk("areset.valid", 160'(bus.ex_valid), 160'(0));
        chk("areset.ctrl", 160'(dut_ctrl()), 160'(0));
        chk("areset.data", 160'(dut_data()), 160'(0));
        chk("areset.cnt", 160'(bus.stall_cnt), 160'(0));
        chk("areset.hazard", 160'(bus.hazard_detected), 160'(0));
        chk("areset.pc_write", 160'(bus.pc_write), 160'(1));
        @(posedge clk);
        #1;
        check_regs("areset_held");
        reset = 1'b0;

        // Saturation: 20 back-to-back load-use conflicts
        in_i = make_lw(8, 8);
        for (int i = 0; i < 40; i++) step("sat");
        chk("sat.cnt", 160'(bus.stall_cnt), 160'(CNT_MAX));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_i     = rand_instr();
            in_stall = ($urandom_range(0, 99) < 15);
            in_flush = ($urandom_range(0, 99) < 10);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the main decoder. It captures the decoder control bits and ID-stage operands for the EX stage. It also detects load-use hazards and drives the decoder's hazard_detected input, the PC write enable and the IF/ID write enable, so that exactly one bubble is inserted per load-use conflict. A saturating counter records hazard stall cycles for performance monitoring.

Parameters:
DATA_W, 32, width of operand, immediate and PC fields
REG_W, 5, register-specifier width
CNT_W, 16, width of the hazard stall counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  global hold (e.g. memory wait); freezes ID/EX contents
flush  in  1  branch-taken squash; turns the captured instruction into a bubble
id_alu_op  in  2  decoder ALUOp
id_alu_src, id_reg_dst, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  decoder control bits
id_rs, id_rt, id_rd  in  REG_W  ID register specifiers
id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W  register-file reads, sign-extended immediate, PC+4
ex_alu_op  out  2  registered ALUOp
ex_alu_src, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  registered control bits
ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers
ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered data
ex_valid  out  1  EX holds a real instruction (not a bubble)
hazard_detected  out  1  load-use hazard; feeds the decoder
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
stall_cnt  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (asynchronous, active-high): all ex_* outputs, ex_valid and stall_cnt go to 0 immediately. Reset holds them at 0 while asserted, including mid-stall or mid-flush.
- hazard_detected is combinational from registered state and ID inputs:
  ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- pc_write = if_id_write = ~(hazard_detected | stall).
- Register update on each rising clk edge, in priority order:
  1. flush=1: all control outputs go to 0 and ex_valid goes to 0. Data fields load the ID inputs; their values are don't-care.
  2. else stall=1: every ex_* register and ex_valid hold their values.
  3. else hazard_detected=1: bubble. All control outputs go to 0 and ex_valid goes to 0. The decoder has already zeroed its outputs; the bubble is enforced here regardless.
  4. else: all fields load from the ID inputs and ex_valid goes to 1.
- Latency: one cycle, ID to EX.
- A bubble clears ex_valid, so hazard_detected drops in the following cycle. The held IF/ID instruction then proceeds. Exactly one bubble is inserted per load-use conflict.
- flush and hazard in the same cycle: the flush wins. The bubble is identical in either case.
- stall and hazard in the same cycle: the registers hold. hazard_detected stays asserted and stall_cnt does not increment.
- stall_cnt increments by 1 on each edge where hazard_detected=1, stall=0 and flush=0. It saturates at 2^CNT_W−1 and never wraps. It is cleared only by reset.
- A register specifier of 0 never causes a hazard.

Test Plan:
- Reset: assert reset mid-cycle with ex_reg_write=1 and stall_cnt=5 -> all outputs are 0 before the next clk edge; hazard_detected=0, pc_write=1.
- R-type pass-through: id_alu_op=2'b10, id_reg_dst=1, id_reg_write=1, id_rdata1=32'h0000_0010 -> one cycle later ex_alu_op=2'b10, ex_rdata1=32'h10, ex_valid=1.
- Load-use: lw with rt=8 captured, then ID presents id_rs=8 -> hazard_detected=1, pc_write=0, if_id_write=0. The next edge gives ex_valid=0 and zero controls with stall_cnt=1. The following cycle has hazard_detected=0 and the dependent instruction loads.
- Zero register: lw rt=0 in EX, ID presents id_rs=0 -> hazard_detected=0, no bubble.
- Stall hold and flush: with stall=1 for 3 cycles, ex_* stay constant and pc_write=0. Then flush=1 together with a valid lw in ID -> ex_valid=0, ex_mem_read=0.
- Saturation (CNT_W=4): 20 back-to-back load-use conflicts -> stall_cnt stops at 15.
